step_clock_gen: RTL

//  Upstream clock source for the single-cycle CPU. Replaces the raw KEY[1]-as-clock path.

---
 rtl/step_clock_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/step_clock_gen.sv
// Clean CPU clock source for the single-cycle CPU.
// A bouncy, asynchronous step button is synchronised and debounced, and each
// accepted press yields exactly one fixed-width oCPU_CLK pulse. In run mode a
// programmable timer generates the pulses instead. A one-cycle strobe and a
// wrapping step counter are provided for the LEDs and the LCD.
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_HIGH      = 4,
  parameter int RUN_PERIOD      = 25000000,
  parameter int CNT_W           = 26
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iKEY_N,
  input  logic       iRUN,
  input  logic [1:0] iRATE,
  output logic       oCPU_CLK,
  output logic       oSTEP,
  output logic       oKEY_DB,
  output logic [7:0] oSTEP_CNT
);

  // Pulse phase counter only needs to reach PULSE_HIGH-1.
  localparam int PH_W = (PULSE_HIGH > 1) ? $clog2(PULSE_HIGH) : 1;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BASE_PER   = CNT_W'(RUN_PERIOD);
  // Shortest period that still leaves a full high and low phase per step.
  localparam logic [CNT_W-1:0] MIN_PER    = CNT_W'(2 * PULSE_HIGH + 2);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(PULSE_HIGH - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HIGH     = 2'd1;
  localparam logic [1:0] ST_LOW_HOLD = 2'd2;

  // Saturate the selected run period at the minimum usable value.
  function automatic logic [CNT_W-1:0] sat_period(input logic [CNT_W-1:0] p);
    return (p < MIN_PER) ? MIN_PER : p;
  endfunction

  logic             key_meta_p0;
  logic             key_sync_p1;
  logic             key_level;
  logic [CNT_W-1:0] db_cnt;
  logic             press_p2;

  logic [CNT_W-1:0] run_period;
  logic [CNT_W-1:0] run_timer;
  logic             timer_hit;
  logic             trigger;

  logic [1:0]       state;
  logic [PH_W-1:0]  ph_cnt;
  logic             ph_done;

  // ---- stage p0/p1: two-flop synchroniser, idles at the released level ----
  // Bring the raw button into the iCLK domain; only key_sync_p1 is used.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      key_meta_p0 <= 1'b1;
      key_sync_p1 <= 1'b1;
    end else begin
      key_meta_p0 <= iKEY_N;
      key_sync_p1 <= key_meta_p0;
    end
  end

  assign key_level = ~key_sync_p1;

  // ---- stage p2: debounce; press_p2 marks the cycle oKEY_DB went 0->1 ----
  // A differing level must persist DEBOUNCE_CYCLES cycles; any match restarts.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      db_cnt   <= '0;
      oKEY_DB  <= 1'b0;
      press_p2 <= 1'b0;
    end else begin
      press_p2 <= 1'b0;
      if (key_level != oKEY_DB) begin
        if (db_cnt == DB_LAST) begin
          db_cnt   <= '0;
          oKEY_DB  <= key_level;
          press_p2 <= key_level;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Rate select divides the base period by 4^iRATE before saturation.
  assign run_period = sat_period(BASE_PER >> {iRATE, 1'b0});

  // '>=' makes a rate change to a shorter period fire at once instead of
  // letting the timer run past its new terminal count.
  assign timer_hit = (run_timer >= (run_period - CNT_W'(1)));

  // Free-running step timer; parked at zero so run mode starts a full period late.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      run_timer <= '0;
    end else if (!iRUN) begin
      run_timer <= '0;
    end else if (timer_hit) begin
      run_timer <= '0;
    end else begin
      run_timer <= run_timer + CNT_W'(1);
    end
  end

  // Key presses only count in step mode; the timer only counts in run mode.
  assign trigger = (!iRUN && press_p2) || (iRUN && timer_hit);

  assign ph_done = (ph_cnt == PH_LAST);

  // ---- stage p3: pulse shaper; triggers outside IDLE are dropped ----
  // Emits one PULSE_HIGH-wide high phase followed by an equal forced low phase.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= ST_IDLE;
      ph_cnt    <= '0;
      oCPU_CLK  <= 1'b0;
      oSTEP     <= 1'b0;
      oSTEP_CNT <= 8'd0;
    end else begin
      oSTEP <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state     <= ST_HIGH;
            ph_cnt    <= '0;
            oCPU_CLK  <= 1'b1;
            oSTEP     <= 1'b1;
            oSTEP_CNT <= oSTEP_CNT + 8'd1;
          end
        end
        ST_HIGH: begin
          if (ph_done) begin
            state    <= ST_LOW_HOLD;
            ph_cnt   <= '0;
            oCPU_CLK <= 1'b0;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
        ST_LOW_HOLD: begin
          if (ph_done) begin
            state  <= ST_IDLE;
            ph_cnt <= '0;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          ph_cnt   <= '0;
          oCPU_CLK <= 1'b0;
        end
      endcase
    end
  end

endmodule
